// File: rtl/uart_arb_if.sv
// uart_arb_if: requester/transmitter bundle for the UART arbiter.
// Ports: req_i, data_i, tx_busy_i in; ack_o, gnt_o, tx_byte_o, tx_byte_v_o out.
interface uart_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] data_i;
  logic [NREQ-1:0]   ack_o;
  logic [NREQ-1:0]   gnt_o;
  logic [7:0]        tx_byte_o;
  logic              tx_byte_v_o;
  logic              tx_busy_i;

  modport master (
    output req_i,
    output data_i,
    output tx_busy_i,
    input  ack_o,
    input  gnt_o,
    input  tx_byte_o,
    input  tx_byte_v_o
  );

  modport slave (
    input  req_i,
    input  data_i,
    input  tx_busy_i,
    output ack_o,
    output gnt_o,
    output tx_byte_o,
    output tx_byte_v_o
  );
endinterface

// File: rtl/uart_arb.sv
// uart_arb: shares one UART transmitter among NREQ byte requesters.
// Ports: clk_i, rst_i (async high), bus (uart_arb_if.slave).
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed priority (index 0 wins).
module uart_arb #(
  parameter int NREQ    = 4,
  parameter int HOLD_TO = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  uart_arb_if.slave  bus
);

  localparam int CW = $clog2(HOLD_TO + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    DRAIN
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [7:0]        r_byte;
  logic              r_v;
  logic [CW-1:0]     r_cnt;

  logic              w_any;
  logic [NREQ-1:0]   w_win;
  logic [7:0]        w_byte;

  assign w_any = |bus.req_i;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Isolate the lowest set request bit.
  assign w_win = bus.req_i & (~bus.req_i + NREQ'(1));
`else
  // One-hot search pointer; requests at or above it win first,
  // otherwise wrap to the lowest request overall.
  logic [NREQ-1:0] r_ptr;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;

  assign w_mask = ~(r_ptr - NREQ'(1));
  assign w_hi   = bus.req_i & w_mask;
  assign w_sel  = (|w_hi) ? w_hi : bus.req_i;
  assign w_win  = w_sel & (~w_sel + NREQ'(1));
`endif

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win[k]) begin
        w_byte = w_byte | bus.data_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_byte  <= '0;
      r_v     <= 1'b0;
      r_cnt   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_ptr   <= NREQ'(1);
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_ack   <= w_win;
            r_byte  <= w_byte;
            r_v     <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_v     <= 1'b0;
          r_ack   <= '0;
          r_cnt   <= '0;
          r_state <= HOLD;
`ifndef UART_ARB_FIXED_PRIO_EN
          // Next search starts just past the winner.
          r_ptr   <= {r_gnt[NREQ-2:0], r_gnt[NREQ-1]};
`endif
        end
        HOLD: begin
          if (bus.tx_busy_i) begin
            r_state <= DRAIN;
          end else if (r_cnt == HOLD_LAST) begin
            // Transmitter never picked the byte up.
            r_gnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (!bus.tx_busy_i) begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_v     <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o       = r_ack;
  assign bus.gnt_o       = r_gnt;
  assign bus.tx_byte_o   = r_byte;
  assign bus.tx_byte_v_o = r_v;

endmodule

// File: tb/tb_uart_arb.sv
// tb_uart_arb: directed checks for uart_arb (NREQ=4, HOLD_TO=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_arb;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  uart_arb_if #(.NREQ(NREQ)) bus ();

  uart_arb #(
    .NREQ(NREQ),
    .HOLD_TO(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller sets req_i while the arbiter is idle; returns back in IDLE.
  task automatic xfer(input string tag,
                      input logic [3:0] g,
                      input logic [7:0] b,
                      input int nbusy);
    logic [31:0] sav;
    step(1);
    chk({tag, ":v"},    32'(bus.tx_byte_v_o), 32'd1);
    chk({tag, ":ack"},  32'(bus.ack_o),       32'(g));
    chk({tag, ":gnt"},  32'(bus.gnt_o),       32'(g));
    chk({tag, ":byte"}, 32'(bus.tx_byte_o),   32'(b));
    bus.req_i = bus.req_i & ~g;
    sav = bus.data_i;
    bus.data_i = ~sav;
    step(1);
    chk({tag, ":hold_v"},   32'(bus.tx_byte_v_o), 32'd0);
    chk({tag, ":hold_ack"}, 32'(bus.ack_o),       32'd0);
    chk({tag, ":hold_gnt"}, 32'(bus.gnt_o),       32'(g));
    bus.tx_busy_i = 1'b1;
    step(1);
    for (int i = 1; i < nbusy; i++) begin
      chk({tag, ":drain_gnt"}, 32'(bus.gnt_o), 32'(g));
      chk({tag, ":drain_ack"}, 32'(bus.ack_o), 32'd0);
      step(1);
    end
    bus.tx_busy_i = 1'b0;
    chk({tag, ":last_gnt"}, 32'(bus.gnt_o), 32'(g));
    step(1);
    chk({tag, ":idle_gnt"},  32'(bus.gnt_o),       32'd0);
    chk({tag, ":idle_v"},    32'(bus.tx_byte_v_o), 32'd0);
    chk({tag, ":idle_byte"}, 32'(bus.tx_byte_o),   32'(b));
    bus.data_i = sav;
  endtask

  logic [3:0] rr_exp [5];
  logic [7:0] rr_byte [5];

  initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
    rr_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rr_byte = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_byte = '{8'h11, 8'h22, 8'hD9, 8'h44, 8'h11};
`endif
    rst = 1'b0;
    bus.req_i = '0;
    bus.data_i = {8'h44, 8'hD9, 8'h22, 8'h11};
    bus.tx_busy_i = 1'b0;
    #1 rst = 1'b1;
    step(2);
    chk("rst_gnt",  32'(bus.gnt_o),       32'd0);
    chk("rst_ack",  32'(bus.ack_o),       32'd0);
    chk("rst_v",    32'(bus.tx_byte_v_o), 32'd0);
    chk("rst_byte", 32'(bus.tx_byte_o),   32'd0);
    rst = 1'b0;

    // Round robin with all requests held.
    for (int i = 0; i < 5; i++) begin
      bus.req_i = 4'b1111;
      xfer("rr", rr_exp[i], rr_byte[i], 1);
    end
    bus.req_i = '0;
    step(1);

    // Single request, long busy.
    bus.req_i = 4'b0100;
    xfer("single", 4'b0100, 8'hD9, 10);

    // Pointer past 3 wraps to 0, then 1.
    bus.req_i = 4'b0011;
    xfer("wrap0", 4'b0001, 8'h11, 2);
    xfer("wrap1", 4'b0010, 8'h22, 2);

    // Lost issue: busy never rises.
    bus.req_i = 4'b1000;
    step(1);
    chk("lost_v",   32'(bus.tx_byte_v_o), 32'd1);
    chk("lost_gnt", 32'(bus.gnt_o),       32'd8);
    bus.req_i = '0;
    step(4);
    chk("lost_hold_gnt", 32'(bus.gnt_o), 32'd8);
    step(1);
    chk("lost_idle_gnt", 32'(bus.gnt_o), 32'd0);
    bus.req_i = 4'b0001;
    xfer("after_lost", 4'b0001, 8'h11, 1);

    // Reset while draining.
    bus.req_i = 4'b0010;
    step(1);
    chk("pre_rst_ack", 32'(bus.ack_o), 32'd2);
    bus.req_i = '0;
    step(1);
    bus.tx_busy_i = 1'b1;
    step(1);
    chk("pre_rst_gnt", 32'(bus.gnt_o), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_gnt",  32'(bus.gnt_o),       32'd0);
    chk("mid_rst_ack",  32'(bus.ack_o),       32'd0);
    chk("mid_rst_v",    32'(bus.tx_byte_v_o), 32'd0);
    chk("mid_rst_byte", 32'(bus.tx_byte_o),   32'd0);
    bus.tx_busy_i = 1'b0;
    step(1);
    chk("rst_held_ack", 32'(bus.ack_o), 32'd0);
    rst = 1'b0;
    bus.req_i = 4'b0110;
    xfer("rst_rearb", 4'b0010, 8'h22, 2);

    // Request withdrawn right after ack.
    bus.req_i = 4'b1000;
    xfer("withdraw", 4'b1000, 8'h44, 3);
    step(1);
    chk("withdraw_ack", 32'(bus.ack_o), 32'd0);
    chk("withdraw_gnt", 32'(bus.gnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
